mac_int8_x2_ctrl: RTL and testbench

Sequencing controller for the packed dual int8 multiplier (cal_mult_int8_x2) in the convolution engine. It accepts a stream of operand triples (a, b, c), issues one triple per cycle to the multiplier, and accumulates a·c and b·c into two signed accumulators over a programmed length. It returns the two dot-products through a valid/ready handshake. One instance feeds each output-channel pair of the PE array.

---
 rtl/mac_int8_x2_ctrl.sv | 203 ++++++++++++++++++++
 tb/tb_mac_int8_x2_ctrl.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_int8_x2_ctrl.sv
// mac_int8_x2_ctrl: sequencing controller for a packed dual int8 multiplier.
// Accepts (a, b, c) operand triples, issues one per cycle to a MUL_LAT-deep
// multiplier, and accumulates a*c and b*c over a programmed job length.
// Build option: define MAC_X2_SAT_EN for saturating accumulation with a sticky
// out_ovf_o flag; otherwise adds wrap and out_ovf_o is tied low.
// Ports:
//   clk, rst                      clock, async active-high reset
//   start_i, cfg_len_i            job start and length (latched in IDLE)
//   busy_o                        high outside IDLE
//   in_valid_i/in_ready_o         operand handshake, in_a_i/in_b_i/in_c_i int8
//   out_valid_o/out_ready_i       result handshake
//   out_acc_a_o, out_acc_b_o      signed sums of a*c and b*c
//   out_ovf_o                     sticky saturation flag for the job
module mac_int8_x2_ctrl #(
  parameter int unsigned ACC_W   = 32,
  parameter int unsigned LEN_W   = 16,
  parameter int unsigned MUL_LAT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [LEN_W-1:0] cfg_len_i,
  output logic             busy_o,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [7:0]       in_a_i,
  input  logic [7:0]       in_b_i,
  input  logic [7:0]       in_c_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [ACC_W-1:0] out_acc_a_o,
  output logic [ACC_W-1:0] out_acc_b_o,
  output logic             out_ovf_o
);

  localparam int unsigned PROD_W = 16;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, OUT} state_e;

  state_e                   state_q, state_d;
  logic [LEN_W-1:0]         len_q, len_d;
  logic [LEN_W-1:0]         cnt_q, cnt_d;
  logic                     hold_q, hold_d;
  logic [MUL_LAT:0]         pipe_q, pipe_d;
  logic signed [7:0]        a_q, b_q, c_q;
  logic signed [PROD_W-1:0] prod_a_q [MUL_LAT];
  logic signed [PROD_W-1:0] prod_b_q [MUL_LAT];
  logic signed [PROD_W-1:0] mul_ac_c, mul_bc_c;
  logic signed [ACC_W-1:0]  acc_a_q, acc_a_d;
  logic signed [ACC_W-1:0]  acc_b_q, acc_b_d;
  logic                     busy_q, in_ready_q, out_valid_q;
  logic                     accept_c;

`ifdef MAC_X2_SAT_EN
  localparam int unsigned     SUM_W   = ACC_W + 1;
  localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  logic             ovf_q, ovf_d;
  logic [ACC_W:0]   sat_a_c, sat_b_c;

  // Saturating add; MSB of the result flags a clip.
  function automatic logic [ACC_W:0] sat_add(input logic signed [ACC_W-1:0] acc,
                                             input logic signed [PROD_W-1:0] p);
    logic signed [SUM_W-1:0] s;
    s = SUM_W'(acc) + SUM_W'(p);
    if (s[ACC_W] != s[ACC_W-1]) return {1'b1, (s[ACC_W] ? ACC_MIN : ACC_MAX)};
    return {1'b0, s[ACC_W-1:0]};
  endfunction
`endif

  // Exact int8 x int8 products of the registered operands.
  assign mul_ac_c = PROD_W'(a_q) * PROD_W'(c_q);
  assign mul_bc_c = PROD_W'(b_q) * PROD_W'(c_q);

  // Next-state, counter, valid pipe and accumulator update.
  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    cnt_d    = cnt_q;
    hold_d   = 1'b0;
    accept_c = 1'b0;
    acc_a_d  = acc_a_q;
    acc_b_d  = acc_b_q;
`ifdef MAC_X2_SAT_EN
    ovf_d    = ovf_q;
    sat_a_c  = sat_add(acc_a_q, prod_a_q[MUL_LAT-1]);
    sat_b_c  = sat_add(acc_b_q, prod_b_q[MUL_LAT-1]);
`endif

    case (state_q)
      IDLE: begin
        if (start_i) begin
          len_d = cfg_len_i;
          cnt_d = '0;
          if (cfg_len_i == '0) begin
            state_d = DRAIN;
            // Empty job dwells one extra DRAIN cycle for a fixed 2-cycle result.
            hold_d  = 1'b1;
          end else begin
            state_d = RUN;
          end
        end
      end
      RUN: begin
        if (in_valid_i) begin
          accept_c = 1'b1;
          cnt_d    = cnt_q + LEN_W'(1);
          if (cnt_d == len_q) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (pipe_q == '0 && !hold_q) state_d = OUT;
      end
      OUT: begin
        if (out_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    pipe_d = {pipe_q[MUL_LAT-1:0], accept_c};

    if (state_q == IDLE && start_i) begin
      acc_a_d = '0;
      acc_b_d = '0;
`ifdef MAC_X2_SAT_EN
      ovf_d   = 1'b0;
`endif
    end else if (pipe_q[MUL_LAT]) begin
`ifdef MAC_X2_SAT_EN
      acc_a_d = sat_a_c[ACC_W-1:0];
      acc_b_d = sat_b_c[ACC_W-1:0];
      ovf_d   = ovf_q | sat_a_c[ACC_W] | sat_b_c[ACC_W];
`else
      acc_a_d = acc_a_q + ACC_W'(prod_a_q[MUL_LAT-1]);
      acc_b_d = acc_b_q + ACC_W'(prod_b_q[MUL_LAT-1]);
`endif
    end
  end

  // State, datapath and registered status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      len_q       <= '0;
      cnt_q       <= '0;
      hold_q      <= 1'b0;
      pipe_q      <= '0;
      a_q         <= '0;
      b_q         <= '0;
      c_q         <= '0;
      for (int i = 0; i < MUL_LAT; i++) begin
        prod_a_q[i] <= '0;
        prod_b_q[i] <= '0;
      end
      acc_a_q     <= '0;
      acc_b_q     <= '0;
      busy_q      <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
`ifdef MAC_X2_SAT_EN
      ovf_q       <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      hold_q  <= hold_d;
      pipe_q  <= pipe_d;
      if (accept_c) begin
        a_q <= in_a_i;
        b_q <= in_b_i;
        c_q <= in_c_i;
      end
      prod_a_q[0] <= mul_ac_c;
      prod_b_q[0] <= mul_bc_c;
      for (int i = 1; i < MUL_LAT; i++) begin
        prod_a_q[i] <= prod_a_q[i-1];
        prod_b_q[i] <= prod_b_q[i-1];
      end
      acc_a_q     <= acc_a_d;
      acc_b_q     <= acc_b_d;
      busy_q      <= (state_d != IDLE);
      in_ready_q  <= (state_d == RUN);
      out_valid_q <= (state_d == OUT);
`ifdef MAC_X2_SAT_EN
      ovf_q       <= ovf_d;
`endif
    end
  end

  assign busy_o      = busy_q;
  assign in_ready_o  = in_ready_q;
  assign out_valid_o = out_valid_q;
  assign out_acc_a_o = acc_a_q;
  assign out_acc_b_o = acc_b_q;
`ifdef MAC_X2_SAT_EN
  assign out_ovf_o   = ovf_q;
`else
  assign out_ovf_o   = 1'b0;
`endif

endmodule

// File: tb/tb_mac_int8_x2_ctrl.sv
// Directed bench for mac_int8_x2_ctrl: a 32-bit and a 16-bit accumulator
// instance share all stimulus; expected sums are hand-computed constants.
module tb_mac_int8_x2_ctrl;

`ifdef MAC_X2_SAT_EN
  localparam int   EXP_SAT_A16 = 32767;
  localparam logic EXP_OVF16   = 1'b1;
`else
  localparam int   EXP_SAT_A16 = -16384;
  localparam logic EXP_OVF16   = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [15:0] cfg_len = '0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [7:0]  in_a = '0, in_b = '0, in_c = '0;

  logic        busy32, rdy32, ov32, ovf32;
  logic [31:0] acca32, accb32;
  logic        busy16, rdy16, ov16, ovf16;
  logic [15:0] acca16, accb16;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int hs32 = 0;

  mac_int8_x2_ctrl #(.ACC_W(32), .LEN_W(16), .MUL_LAT(2)) u_dut32 (
    .clk(clk), .rst(rst), .start_i(start), .cfg_len_i(cfg_len), .busy_o(busy32),
    .in_valid_i(in_valid), .in_ready_o(rdy32), .in_a_i(in_a), .in_b_i(in_b), .in_c_i(in_c),
    .out_valid_o(ov32), .out_ready_i(out_ready), .out_acc_a_o(acca32), .out_acc_b_o(accb32),
    .out_ovf_o(ovf32));

  mac_int8_x2_ctrl #(.ACC_W(16), .LEN_W(16), .MUL_LAT(2)) u_dut16 (
    .clk(clk), .rst(rst), .start_i(start), .cfg_len_i(cfg_len), .busy_o(busy16),
    .in_valid_i(in_valid), .in_ready_o(rdy16), .in_a_i(in_a), .in_b_i(in_b), .in_c_i(in_c),
    .out_valid_o(ov16), .out_ready_i(out_ready), .out_acc_a_o(acca16), .out_acc_b_o(accb16),
    .out_ovf_o(ovf16));

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc++;
    if (ov32 === 1'b1 && out_ready === 1'b1) hs32++;
  end

  // Start a job; afterwards we sit at the negedge following accept edge S.
  task automatic job_start(input int len);
    start = 1'b1;
    cfg_len = 16'(len);
    @(negedge clk);
    start = 1'b0;
    checks++;
    if ({busy32, rdy32, busy16, rdy16} !== 4'b1111) begin
      failures++;
      $display("FAIL start_latency busy/ready=%b%b%b%b exp=1111", busy32, rdy32, busy16, rdy16);
    end
  endtask

  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    checks++;
    if (rdy32 !== 1'b1) begin
      failures++;
      $display("FAIL send_ready in_ready=%b exp=1", rdy32);
    end
    in_valid = 1'b1; in_a = a; in_b = b; in_c = c;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_out(input string tag, output int at);
    int n;
    n = 0;
    while (ov32 !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    at = cyc;
    checks++;
    if ({ov32, ov16} !== 2'b11) begin
      failures++;
      $display("FAIL %s_out_valid got=%b%b exp=11", tag, ov32, ov16);
    end
  endtask

  task automatic handshake(input string tag);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checks++;
    if ({ov32, busy32, ov16, busy16} !== 4'b0000) begin
      failures++;
      $display("FAIL %s_handshake valid/busy=%b%b%b%b exp=0000", tag, ov32, busy32, ov16, busy16);
    end
  endtask

  task automatic check_sums(input string tag, input int ea, input int eb);
    checks++;
    if ($signed(acca32) !== ea || $signed(accb32) !== eb) begin
      failures++;
      $display("FAIL %s_sum32 got=%0d,%0d exp=%0d,%0d", tag, $signed(acca32), $signed(accb32), ea, eb);
    end
    checks++;
    if ($signed(acca16) !== ea || $signed(accb16) !== eb) begin
      failures++;
      $display("FAIL %s_sum16 got=%0d,%0d exp=%0d,%0d", tag, $signed(acca16), $signed(accb16), ea, eb);
    end
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy32, rdy32, ov32, ovf32, busy16, rdy16, ov16, ovf16} !== 8'b0 ||
        acca32 !== 32'd0 || accb32 !== 32'd0 || acca16 !== 16'd0 || accb16 !== 16'd0) begin
      failures++;
      $display("FAIL reset_values status=%b%b%b%b acc=%0d,%0d exp=0000 acc=0,0",
               busy32, rdy32, ov32, ovf32, $signed(acca32), $signed(accb32));
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy32, rdy32, ov32, busy16} !== 4'b0) begin
      failures++;
      $display("FAIL reset_release status=%b%b%b%b exp=0000", busy32, rdy32, ov32, busy16);
    end
  endtask

  task automatic test_basic();
    int e, at;
    job_start(3);
    send(8'sd1, -8'sd2, 8'sd3);
    send(-8'sd128, 8'sd127, -8'sd128);
    send(8'sd5, 8'sd5, -8'sd1);
    e = cyc;
    wait_out("basic", at);
    checks++;
    if (at - e !== 4) begin
      failures++;
      $display("FAIL basic_latency got=%0d exp=4", at - e);
    end
    check_sums("basic", 16382, -16267);
    checks++;
    if ({ovf32, ovf16} !== 2'b00) begin
      failures++;
      $display("FAIL basic_ovf got=%b%b exp=00", ovf32, ovf16);
    end
    handshake("basic");
  endtask

  task automatic test_gapped_backpressure();
    int at, hs0;
    job_start(3);
    send(8'sd1, -8'sd2, 8'sd3);
    @(negedge clk);
    send(-8'sd128, 8'sd127, -8'sd128);
    @(negedge clk);
    send(8'sd5, 8'sd5, -8'sd1);
    wait_out("gapped", at);
    hs0 = hs32;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (ov32 !== 1'b1 || $signed(acca32) !== 16382 || $signed(accb32) !== -16267) begin
        failures++;
        $display("FAIL gapped_hold cyc%0d valid=%b acc=%0d,%0d exp=1 16382,-16267",
                 i, ov32, $signed(acca32), $signed(accb32));
      end
    end
    handshake("gapped");
    repeat (3) @(negedge clk);
    checks++;
    if (hs32 - hs0 !== 1 || ov32 !== 1'b0) begin
      failures++;
      $display("FAIL gapped_one_handshake got=%0d valid=%b exp=1 valid=0", hs32 - hs0, ov32);
    end
  endtask

  task automatic test_zero_len();
    out_ready = 1'b1;
    start = 1'b1;
    cfg_len = 16'd0;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if ({ov32, rdy32, rdy16} !== 3'b000) begin
      failures++;
      $display("FAIL zero_s1 valid/ready=%b%b%b exp=000", ov32, rdy32, rdy16);
    end
    @(negedge clk);
    checks++;
    if ({ov32, rdy32, rdy16} !== 3'b000) begin
      failures++;
      $display("FAIL zero_s2 valid/ready=%b%b%b exp=000", ov32, rdy32, rdy16);
    end
    @(negedge clk);
    checks++;
    if ({ov32, ov16, rdy32} !== 3'b110) begin
      failures++;
      $display("FAIL zero_valid valid/ready=%b%b%b exp=110", ov32, ov16, rdy32);
    end
    check_sums("zero", 0, 0);
    @(negedge clk);
    out_ready = 1'b0;
    checks++;
    if ({ov32, busy32} !== 2'b00) begin
      failures++;
      $display("FAIL zero_early_ready valid/busy=%b%b exp=00", ov32, busy32);
    end
  endtask

  task automatic test_saturation();
    int at;
    job_start(3);
    repeat (3) send(-8'sd128, 8'sd0, -8'sd128);
    wait_out("sat", at);
    checks++;
    if ($signed(acca16) !== EXP_SAT_A16 || accb16 !== 16'd0 || ovf16 !== EXP_OVF16) begin
      failures++;
      $display("FAIL sat_acc16 got=%0d,%0d ovf=%b exp=%0d,0 ovf=%b",
               $signed(acca16), $signed(accb16), ovf16, EXP_SAT_A16, EXP_OVF16);
    end
    checks++;
    if ($signed(acca32) !== 49152 || accb32 !== 32'd0 || ovf32 !== 1'b0) begin
      failures++;
      $display("FAIL sat_acc32 got=%0d,%0d ovf=%b exp=49152,0 ovf=0",
               $signed(acca32), $signed(accb32), ovf32);
    end
  endtask

  task automatic test_back_to_back();
    int at;
    handshake("b2b_prev");
    job_start(2);
    send(8'sd3, -8'sd4, 8'sd5);
    send(-8'sd7, 8'sd2, -8'sd1);
    wait_out("b2b", at);
    check_sums("b2b", 22, -22);
    checks++;
    if ({ovf32, ovf16} !== 2'b00) begin
      failures++;
      $display("FAIL b2b_ovf_cleared got=%b%b exp=00", ovf32, ovf16);
    end
    handshake("b2b");
  endtask

  task automatic test_reset_mid_job();
    int at;
    bit seen;
    job_start(4);
    send(8'sd10, 8'sd20, 8'sd3);
    send(8'sd1, 8'sd1, 8'sd1);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if ({busy32, rdy32, ov32, ovf32, busy16, rdy16, ov16, ovf16} !== 8'b0 ||
        acca32 !== 32'd0 || accb32 !== 32'd0 || acca16 !== 16'd0 || accb16 !== 16'd0) begin
      failures++;
      $display("FAIL midrst_async status=%b%b%b acc=%0d,%0d exp=000 acc=0,0",
               busy32, rdy32, ov32, $signed(acca32), $signed(accb32));
    end
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (ov32 === 1'b1 || ov16 === 1'b1 || busy32 === 1'b1) seen = 1;
    end
    checks++;
    if (seen !== 1'b0) begin
      failures++;
      $display("FAIL midrst_no_result seen=%b exp=0", seen);
    end
    job_start(1);
    send(8'sd2, 8'sd3, 8'sd4);
    wait_out("midrst", at);
    check_sums("midrst", 8, 12);
    handshake("midrst");
  endtask

  task automatic test_protocol();
    int at;
    job_start(2);
    start = 1'b1;
    cfg_len = 16'd7;
    send(8'sd4, -8'sd3, 8'sd6);
    start = 1'b0;
    in_valid = 1'b1; in_a = -8'sd2; in_b = 8'sd7; in_c = 8'sd8;
    @(negedge clk);
    in_a = 8'sd99; in_b = 8'sd99; in_c = 8'sd99;
    checks++;
    if ({rdy32, rdy16, busy32} !== 3'b001) begin
      failures++;
      $display("FAIL proto_drain_ready ready/busy=%b%b%b exp=001", rdy32, rdy16, busy32);
    end
    repeat (3) @(negedge clk);
    in_valid = 1'b0;
    wait_out("proto", at);
    check_sums("proto", 8, 38);
    start = 1'b1;
    repeat (2) @(negedge clk);
    start = 1'b0;
    checks++;
    if ({ov32, busy32} !== 2'b11 || $signed(acca32) !== 8 || $signed(accb32) !== 38) begin
      failures++;
      $display("FAIL proto_start_in_out valid/busy=%b%b acc=%0d,%0d exp=11 8,38",
               ov32, busy32, $signed(acca32), $signed(accb32));
    end
    handshake("proto");
    in_valid = 1'b1; in_a = 8'sd50; in_b = 8'sd50; in_c = 8'sd50;
    repeat (3) @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if ({busy32, rdy32, busy16, rdy16} !== 4'b0000) begin
      failures++;
      $display("FAIL proto_idle_valid busy/ready=%b%b%b%b exp=0000", busy32, rdy32, busy16, rdy16);
    end
    job_start(1);
    send(8'sd1, 8'sd1, 8'sd1);
    wait_out("proto2", at);
    check_sums("proto2", 1, 1);
    handshake("proto2");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_gapped_backpressure();
    test_zero_len();
    test_saturation();
    test_back_to_back();
    test_reset_mid_job();
    test_protocol();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
